// File: rtl/dac_spi_tx.sv
// dac_spi_tx: frames a 12-bit sample as {cfg,data} and shifts it to an SPI DAC
// Ports: clk/rst_n, sample_in/valid/ready in, dac_cs_n/sck/mosi/ldac_n, busy, frame_done out
module dac_spi_tx #(
  parameter int         CLK_DIV  = 4,
  parameter logic [3:0] CFG_BITS = 4'b0111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        dac_cs_n,
  output logic        dac_sck,
  output logic        dac_mosi,
  output logic        dac_ldac_n,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    LATCH
  } state_t;

  localparam logic [7:0] HMAX = 8'(CLK_DIV - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [3:0]  bit_cnt;
  logic [14:0] shreg;
  logic        last;

  assign last = (cnt == HMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      sample_ready <= 1'b1;
      dac_cs_n     <= 1'b1;
      dac_sck      <= 1'b0;
      dac_mosi     <= 1'b0;
      dac_ldac_n   <= 1'b1;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sample_valid && sample_ready) begin
            // word[15] goes straight to mosi; the rest waits in shreg
            shreg        <= {CFG_BITS[2:0], sample_in};
            dac_mosi     <= CFG_BITS[3];
            dac_cs_n     <= 1'b0;
            sample_ready <= 1'b0;
            busy         <= 1'b1;
            cnt          <= '0;
            state        <= SETUP;
          end
        end
        SETUP: begin
          if (last) begin
            cnt     <= '0;
            dac_sck <= 1'b1;
            bit_cnt <= 4'd15;
            state   <= SHIFT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        SHIFT: begin
          if (!last) begin
            cnt <= cnt + 8'd1;
          end else begin
            cnt <= '0;
            if (dac_sck) begin
              // falling edge: present the next lower bit
              dac_sck  <= 1'b0;
              dac_mosi <= shreg[14];
              shreg    <= {shreg[13:0], 1'b0};
            end else if (bit_cnt == 4'd0) begin
              dac_cs_n <= 1'b1;
              dac_mosi <= 1'b0;
              state    <= HOLD;
            end else begin
              bit_cnt <= bit_cnt - 4'd1;
              dac_sck <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (last) begin
            cnt        <= '0;
            dac_ldac_n <= 1'b0;
            state      <= LATCH;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        LATCH: begin
          if (last) begin
            cnt          <= '0;
            dac_ldac_n   <= 1'b1;
            frame_done   <= 1'b1;
            sample_ready <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: directed checks of dac_spi_tx at CLK_DIV=2 (u0) and 1 (u1)
// Ports: none
module tb_dac_spi_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] sin [2];
  logic        sval [2];
  logic        rdy [2];
  logic        cs [2];
  logic        sck [2];
  logic        mosi [2];
  logic        ldac [2];
  logic        bsy [2];
  logic        done [2];

  always #5 clk = ~clk;

  dac_spi_tx #(.CLK_DIV(2), .CFG_BITS(4'b0111)) u0 (
    .clk(clk), .rst_n(rst_n),
    .sample_in(sin[0]), .sample_valid(sval[0]),
    .sample_ready(rdy[0]), .dac_cs_n(cs[0]),
    .dac_sck(sck[0]), .dac_mosi(mosi[0]),
    .dac_ldac_n(ldac[0]), .busy(bsy[0]),
    .frame_done(done[0])
  );

  dac_spi_tx #(.CLK_DIV(1), .CFG_BITS(4'b0111)) u1 (
    .clk(clk), .rst_n(rst_n),
    .sample_in(sin[1]), .sample_valid(sval[1]),
    .sample_ready(rdy[1]), .dac_cs_n(cs[1]),
    .dac_sck(sck[1]), .dac_mosi(mosi[1]),
    .dac_ldac_n(ldac[1]), .busy(bsy[1]),
    .frame_done(done[1])
  );

  int cmp = 0;
  int err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // bus monitor, sampled on the falling clock edge
  logic [15:0] cap [2];
  int          nr [2];
  logic [15:0] fw [2][2048];
  int          fn [2][2048];
  int          nf [2];
  int          ndone [2];
  int          ntog [2];
  int          gap [2];
  int          g [2];
  bit          armed [2];
  int          hi [2];
  int          nacc [2];
  int          acc_t [2][2048];
  int          hs [2][2048];
  logic        psck [2];
  logic        pcs [2];
  logic        prdy [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      cap[i] = '0; nr[i] = 0; nf[i] = 0; ndone[i] = 0;
      ntog[i] = 0; gap[i] = 0; g[i] = 0; armed[i] = 0;
      hi[i] = 0; nacc[i] = 0;
      psck[i] = 0; pcs[i] = 1; prdy[i] = 1;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (sck[i] !== psck[i]) ntog[i]++;
      if (sck[i] && !psck[i] && !cs[i]) begin
        cap[i] = {cap[i][14:0], mosi[i]};
        nr[i]++;
      end
      if (!cs[i] && pcs[i]) begin
        cap[i] = '0;
        nr[i] = 0;
      end
      if (cs[i] && !pcs[i]) begin
        fw[i][nf[i] % 2048] = cap[i];
        fn[i][nf[i] % 2048] = nr[i];
        nf[i]++;
        hi[i] = 1;
        armed[i] = 1;
        g[i] = 1;
      end else begin
        if (cs[i]) hi[i]++;
        if (armed[i]) begin
          if (!ldac[i]) begin
            gap[i] = g[i];
            armed[i] = 0;
          end else begin
            g[i]++;
          end
        end
      end
      if (done[i]) ndone[i]++;
      if (prdy[i] && !rdy[i]) begin
        acc_t[i][nacc[i] % 2048] = cyc;
        hs[i][nacc[i] % 2048] = hi[i];
        nacc[i]++;
      end
      psck[i] = sck[i];
      pcs[i] = cs[i];
      prdy[i] = rdy[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // single frame, valid held and sample_in scrambled while busy
  task automatic send(input int i, input logic [11:0] s,
                      input logic [15:0] exp);
    int t;
    int h;
    int d0;
    int f0;
    h = (i == 0) ? 2 : 1;
    d0 = ndone[i];
    f0 = nf[i];
    @(negedge clk);
    sval[i] = 1'b1;
    sin[i] = s;
    @(negedge clk);
    t = 0;
    while (!rdy[i] && t < 400) begin
      sin[i] = 12'($urandom);
      @(negedge clk);
      t++;
    end
    sval[i] = 1'b0;
    chk($sformatf("latency_%0h", s), t, 35 * h);
    @(negedge clk);
    chk($sformatf("frames_%0h", s), nf[i] - f0, 1);
    chk($sformatf("word_%0h", s), {16'h0, fw[i][f0 % 2048]}, {16'h0, exp});
    chk($sformatf("rises_%0h", s), fn[i][f0 % 2048], 16);
    chk($sformatf("done_%0h", s), ndone[i] - d0, 1);
    chk($sformatf("ldac_gap_%0h", s), gap[i], h);
  endtask

  logic [11:0] seq [2048];

  // back-to-back frames on u1 (CLK_DIV=1) with valid held high
  task automatic b2b(input string name, input int n);
    int t;
    int k;
    int f0;
    int a0;
    int lim;
    int bad_w;
    int bad_n;
    int bad_s;
    int bad_h;
    logic pr;
    f0 = nf[1];
    a0 = nacc[1];
    lim = n * 36 + 200;
    @(negedge clk);
    sval[1] = 1'b1;
    sin[1] = seq[0];
    k = 0;
    t = 0;
    pr = rdy[1];
    while (k < n && t < lim) begin
      @(negedge clk);
      t++;
      if (pr && !rdy[1]) begin
        k++;
        if (k < n) sin[1] = seq[k];
        else sval[1] = 1'b0;
      end
      pr = rdy[1];
    end
    while (nf[1] - f0 < n && t < lim) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk({name, "_timeout"}, (t < lim), 1);
    chk({name, "_frames"}, nf[1] - f0, n);
    bad_w = 0; bad_n = 0; bad_s = 0; bad_h = 0;
    for (int j = 0; j < n; j++) begin
      if (fw[1][(f0 + j) % 2048] !== {4'h7, seq[j]}) begin
        if (bad_w == 0)
          $display("FAIL %s_word[%0d]: got %0h expected %0h", name, j,
                   fw[1][(f0 + j) % 2048], {4'h7, seq[j]});
        bad_w++;
      end
      if (fn[1][(f0 + j) % 2048] != 16) bad_n++;
      if (j > 0) begin
        if (acc_t[1][(a0 + j) % 2048] - acc_t[1][(a0 + j - 1) % 2048] != 36)
          bad_s++;
        if (hs[1][(a0 + j) % 2048] < 3) bad_h++;
      end
    end
    chk({name, "_words_bad"}, bad_w, 0);
    chk({name, "_rises_bad"}, bad_n, 0);
    chk({name, "_spacing_bad"}, bad_s, 0);
    chk({name, "_csgap_bad"}, bad_h, 0);
  endtask

  typedef struct {
    int          dut;
    logic [11:0] s;
    logic [15:0] exp;
  } vec_t;

  vec_t vt [6];

  initial begin
    int t;
    int d0;
    int t0;
    int bad;
    int n;
    vt[0] = '{0, 12'hABC, 16'h7ABC};
    vt[1] = '{0, 12'h000, 16'h7000};
    vt[2] = '{0, 12'hFFF, 16'h7FFF};
    vt[3] = '{0, 12'h555, 16'h7555};
    vt[4] = '{1, 12'hA5A, 16'h7A5A};
    vt[5] = '{1, 12'h801, 16'h7801};

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sval[i] = 1'b0;
      sin[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_ready", rdy[0], 1);
    chk("rst_cs_n", cs[0], 1);
    chk("rst_sck", sck[0], 0);
    chk("rst_mosi", mosi[0], 0);
    chk("rst_ldac_n", ldac[0], 1);
    chk("rst_busy", bsy[0], 0);
    chk("rst_done", done[0], 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) send(vt[v].dut, vt[v].s, vt[v].exp);

    // back-to-back min/max samples
    seq[0] = 12'h000;
    seq[1] = 12'hFFF;
    b2b("b2b", 2);

    // abort at bit 8 with an asynchronous reset
    d0 = ndone[0];
    @(negedge clk);
    sval[0] = 1'b1;
    sin[0] = 12'h3C5;
    t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (!(nr[0] == 8 && !cs[0]) && t < 400);
    chk("abort_reach_bit8", (t < 400), 1);
    rst_n = 1'b0;
    sval[0] = 1'b0;
    #1;
    chk("abort_cs_n", cs[0], 1);
    chk("abort_sck", sck[0], 0);
    chk("abort_ldac_n", ldac[0], 1);
    chk("abort_ready", rdy[0], 1);
    chk("abort_busy", bsy[0], 0);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_done", ndone[0] - d0, 0);
    send(0, 12'h321, 16'h7321);

    // long idle: nothing moves
    t0 = ntog[0];
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      sin[0] = 12'($urandom);
      @(negedge clk);
      if (rdy[0] !== 1'b1 || cs[0] !== 1'b1 || sck[0] !== 1'b0 ||
          mosi[0] !== 1'b0 || ldac[0] !== 1'b1 || bsy[0] !== 1'b0 ||
          done[0] !== 1'b0)
        bad++;
    end
    chk("idle_outputs_bad", bad, 0);
    chk("idle_sck_toggles", ntog[0] - t0, 0);

    // triangle 0 -> 2047 -> 0, coarse step to keep the run short
    n = 0;
    for (int v = 0; v < 2047; v += 4) begin
      seq[n] = 12'(v);
      n++;
    end
    seq[n] = 12'd2047;
    n++;
    for (int v = 2044; v >= 0; v -= 4) begin
      seq[n] = 12'(v);
      n++;
    end
    b2b("tri", n);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
